// File: rtl/calc_key_conditioner.sv
// Calculator input front-end: synchronises the operand switches, synchronises and
// debounces the three active-low operator buttons, and emits one key event per press
// episode with a key code and the operand captured alongside it.
module calc_key_conditioner #(
  parameter int unsigned DB_CYCLES = 50000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       plus_raw_n,
  input  logic       minus_raw_n,
  input  logic       equal_raw_n,
  input  logic [7:0] sw_in,
  output logic       plus_n,
  output logic       minus_n,
  output logic       equal_n,
  output logic       key_pulse,
  output logic [1:0] key_code,
  output logic [7:0] operand
);

  // Button bit order: [0] plus, [1] minus, [2] equal.
  localparam int unsigned NumKeys = 3;
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DB_CYCLES - 1);

  typedef enum logic {StIdle, StHeld} state_e;

  logic [NumKeys-1:0]            btn_meta_q, btn_sync_q;
  logic [7:0]                    sw_meta_q, sw_sync_q;
  logic [NumKeys-1:0]            db_q, db_d;
  logic [NumKeys-1:0][CNT_W-1:0] cnt_q, cnt_d;
  state_e                        state_q, state_d;
  logic                          key_pulse_q, key_pulse_d;
  logic [1:0]                    key_code_q, key_code_d;
  logic [7:0]                    operand_q, operand_d;

  // Two-flop synchronisers; buttons idle high, switches idle low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_meta_q <= '1;
      btn_sync_q <= '1;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
    end else begin
      btn_meta_q <= {equal_raw_n, minus_raw_n, plus_raw_n};
      btn_sync_q <= btn_meta_q;
      sw_meta_q  <= sw_in;
      sw_sync_q  <= sw_meta_q;
    end
  end

  // Per-key debounce: level follows the synced input only after DB_CYCLES stable cycles;
  // any return to the current level restarts the count.
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    for (int k = 0; k < NumKeys; k++) begin
      if (btn_sync_q[k] == db_q[k]) begin
        cnt_d[k] = '0;
      end else if (cnt_q[k] == CntLast) begin
        db_d[k]  = btn_sync_q[k];
        cnt_d[k] = '0;
      end else begin
        cnt_d[k] = cnt_q[k] + 1'b1;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_q  <= '1;
      cnt_q <= '0;
    end else begin
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  // Event FSM: one strobe on the first debounced press, then locked out until all keys
  // are released. Code and operand are loaded together with the strobe and held after.
  always_comb begin
    state_d     = state_q;
    key_pulse_d = 1'b0;
    key_code_d  = key_code_q;
    operand_d   = operand_q;
    unique case (state_q)
      StIdle: begin
        if (db_q != '1) begin
          key_pulse_d = 1'b1;
          operand_d   = sw_sync_q;
          state_d     = StHeld;
          // Plus beats minus beats equal; losers are dropped.
          if (!db_q[0]) begin
            key_code_d = 2'b01;
          end else if (!db_q[1]) begin
            key_code_d = 2'b10;
          end else begin
            key_code_d = 2'b11;
          end
        end
      end
      StHeld: begin
        if (db_q == '1) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state and registered event outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      key_pulse_q <= 1'b0;
      key_code_q  <= 2'b00;
      operand_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      key_pulse_q <= key_pulse_d;
      key_code_q  <= key_code_d;
      operand_q   <= operand_d;
    end
  end

  assign plus_n    = db_q[0];
  assign minus_n   = db_q[1];
  assign equal_n   = db_q[2];
  assign key_pulse = key_pulse_q;
  assign key_code  = key_code_q;
  assign operand   = operand_q;

endmodule

// File: tb/tb_calc_key_conditioner.sv
// Directed bench for calc_key_conditioner with a 4-cycle debounce. Expected key events
// (code, operand, edge index) are queued when a press is driven and matched by a monitor
// whenever key_pulse is seen high.
module tb_calc_key_conditioner;

  localparam int unsigned DB  = 4;
  localparam int unsigned LAT = DB + 3;  // edges from first sampling edge to pulse

  logic       clk = 1'b0;
  logic       rst_n;
  logic       plus_raw_n, minus_raw_n, equal_raw_n;
  logic [7:0] sw_in;
  logic       plus_n, minus_n, equal_n, key_pulse;
  logic [1:0] key_code;
  logic [7:0] operand;

  calc_key_conditioner #(
    .DB_CYCLES (DB),
    .CNT_W     (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .plus_raw_n  (plus_raw_n),
    .minus_raw_n (minus_raw_n),
    .equal_raw_n (equal_raw_n),
    .sw_in       (sw_in),
    .plus_n      (plus_n),
    .minus_n     (minus_n),
    .equal_n     (equal_n),
    .key_pulse   (key_pulse),
    .key_code    (key_code),
    .operand     (operand)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  code;
    logic [7:0]  op;
    int unsigned at;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  errors = 0;
  int  checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called right after driving a press: the next edge is the first to sample it.
  task automatic expect_event(input logic [1:0] code, input logic [7:0] op);
    ev_t e;
    e.code = code;
    e.op   = op;
    e.at   = cyc + LAT;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_plus_n"}, plus_n, 1);
    check({tag, "_minus_n"}, minus_n, 1);
    check({tag, "_equal_n"}, equal_n, 1);
    check({tag, "_key_pulse"}, key_pulse, 0);
    check({tag, "_key_code"}, key_code, 0);
    check({tag, "_operand"}, operand, 0);
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (key_pulse === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL spurious_pulse: observed key_code=%0b at edge %0d, expected no pulse",
               key_code, cyc);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("pulse_edge", cyc, mon_e.at);
        check("pulse_code", {30'b0, key_code}, {30'b0, mon_e.code});
        check("pulse_operand", {24'b0, operand}, {24'b0, mon_e.op});
      end
    end
  end

  initial begin
    // Reset with random raw inputs.
    rst_n       = 1'b0;
    plus_raw_n  = 1'($urandom);
    minus_raw_n = 1'($urandom);
    equal_raw_n = 1'($urandom);
    sw_in       = 8'($urandom);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      plus_raw_n  = 1'($urandom);
      minus_raw_n = 1'($urandom);
      equal_raw_n = 1'($urandom);
      sw_in       = 8'($urandom);
    end
    check_reset_outputs("reset");
    plus_raw_n  = 1'b1;
    minus_raw_n = 1'b1;
    equal_raw_n = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(3);

    // Clean press of plus.
    sw_in = 8'h2A;
    tick(3);
    plus_raw_n = 1'b0;
    expect_event(2'b01, 8'h2A);
    tick(5);
    check("clean_plus_n_edge5", plus_n, 1);
    tick(1);
    check("clean_plus_n_edge6", plus_n, 0);
    tick(1);
    check("clean_pulse_edge7", key_pulse, 1);
    tick(1);
    check("clean_pulse_edge8", key_pulse, 0);
    tick(10);
    check("clean_code_held", key_code, 2'b01);
    check("clean_operand_held", operand, 8'h2A);
    check("clean_queue_empty", exp_q.size(), 0);
    plus_raw_n = 1'b1;
    tick(10);

    // Bouncy minus: 2-cycle toggles never reach the terminal count.
    sw_in = 8'h55;
    tick(3);
    for (int i = 0; i < 6; i++) begin
      minus_raw_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) begin
        tick(1);
        check("bounce_minus_n_stable", minus_n, 1);
      end
    end
    minus_raw_n = 1'b0;
    expect_event(2'b10, 8'h55);
    tick(10);
    check("bounce_minus_n_settled", minus_n, 0);
    check("bounce_queue_empty", exp_q.size(), 0);
    minus_raw_n = 1'b1;
    tick(10);

    // Simultaneous plus and equal: plus wins, equal dropped.
    sw_in = 8'h3C;
    tick(3);
    plus_raw_n  = 1'b0;
    equal_raw_n = 1'b0;
    expect_event(2'b01, 8'h3C);
    tick(12);
    plus_raw_n = 1'b1;
    tick(12);
    check("simul_equal_n_held", equal_n, 0);
    check("simul_code_kept", key_code, 2'b01);
    equal_raw_n = 1'b1;
    tick(10);
    check("simul_queue_empty", exp_q.size(), 0);

    // Lockout while held, then equal after full release.
    plus_raw_n = 1'b0;
    expect_event(2'b01, 8'h3C);
    tick(10);
    minus_raw_n = 1'b0;
    tick(10);
    check("lockout_minus_n_tracks", minus_n, 0);
    plus_raw_n  = 1'b1;
    minus_raw_n = 1'b1;
    tick(5);
    sw_in       = 8'hF0;
    equal_raw_n = 1'b0;
    expect_event(2'b11, 8'hF0);
    tick(10);
    check("lockout_queue_empty", exp_q.size(), 0);
    equal_raw_n = 1'b1;
    tick(10);

    // Reset while held; the still-held key must re-debounce fully.
    sw_in = 8'h81;
    tick(3);
    plus_raw_n = 1'b0;
    expect_event(2'b01, 8'h81);
    tick(10);
    check("midrst_pre_queue_empty", exp_q.size(), 0);
    rst_n = 1'b0;
    tick(1);
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    expect_event(2'b01, 8'h81);
    tick(5);
    check("midrst_plus_n_edge5", plus_n, 1);
    tick(1);
    check("midrst_plus_n_edge6", plus_n, 0);
    tick(5);
    plus_raw_n = 1'b1;
    tick(10);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
